// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial parity receiver front-end.
// State encoding, parity-mode constants and default frame geometry.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    localparam logic MODE_ODD  = 1'b0;
    localparam logic MODE_EVEN = 1'b1;

    localparam int DEF_DATA_W       = 4;
    localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/rx_bit_timer.sv
// Oversampling bit timer: free-runs modulo CLKS_PER_BIT, held at zero by restart_i.
// mid_pulse_o marks the start-bit check point, bit_pulse_o the data/parity/stop sample point.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic mid_pulse_o,
    output logic bit_pulse_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID_AT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_AT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == BIT_AT)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_pulse_o = (cnt_q == MID_AT);
    assign bit_pulse_o = (cnt_q == BIT_AT);

endmodule

// File: rtl/serial_parity_rx.sv
// Deserializes start/data/parity/stop frames and holds the last good word for a parity checker.
// Define SERIAL_PARITY_RX_LOCAL_CHECK_EN to build the registered local parity error flag on perr.
module serial_parity_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              mode_in,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_out,
    output logic              trig_out,
    output logic              frame_valid,
    output logic              framing_err,
    output logic              busy,
    output logic              perr
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    rx_state_e state_q, state_d;

    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              parity_q, parity_d;
    logic              trig_q, trig_d;
    logic              fv_q, fv_d;
    logic              ferr_q, ferr_d;

    logic mid_pulse;
    logic bit_pulse;
    logic restart;
    logic frame_start;
    logic sample_data;
    logic sample_parity;
    logic load_frame;
    logic stop_low;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart_i  (restart),
        .mid_pulse_o(mid_pulse),
        .bit_pulse_o(bit_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (!sin) state_d = ST_START;
            ST_START:     if (mid_pulse) state_d = sin ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_pulse && (idx_q == LAST_IDX)) state_d = ST_PARITY;
            ST_PARITY:    if (bit_pulse) state_d = ST_STOP;
            ST_STOP:      if (bit_pulse) state_d = sin ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (sin) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Timer is held in IDLE so START always begins counting from zero.
    always_comb begin
        restart       = (state_q == ST_IDLE) || ((state_q == ST_START) && mid_pulse);
        frame_start   = (state_q == ST_IDLE) && !sin;
        sample_data   = (state_q == ST_DATA) && bit_pulse;
        sample_parity = (state_q == ST_PARITY) && bit_pulse;
        load_frame    = (state_q == ST_STOP) && bit_pulse && sin;
        stop_low      = (state_q == ST_STOP) && bit_pulse && !sin;
        busy          = (state_q != ST_IDLE);
    end

    always_comb begin
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        mode_d   = mode_q;
        data_d   = data_q;
        parity_d = parity_q;
        trig_d   = trig_q;
        fv_d     = load_frame;
        ferr_d   = stop_low;
        if (frame_start) begin
            mode_d = mode_in;
            idx_d  = '0;
        end
        if (sample_data) begin
            shift_d[idx_q] = sin;
            idx_d          = idx_q + IW'(1);
        end
        if (sample_parity) begin
            par_d = sin;
        end
        if (load_frame) begin
            data_d   = shift_q;
            parity_d = par_q;
            trig_d   = mode_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            mode_q   <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            trig_q   <= 1'b0;
            fv_q     <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            trig_q   <= trig_d;
            fv_q     <= fv_d;
            ferr_q   <= ferr_d;
        end
    end

`ifdef SERIAL_PARITY_RX_LOCAL_CHECK_EN
    logic perr_q, perr_d;

    // Odd mode flags the plain XOR, even mode its complement, evaluated on the frame mode.
    always_comb begin
        perr_d = perr_q;
        if (load_frame) begin
            perr_d = (mode_q == MODE_EVEN) ? ~(^{shift_q, par_q}) : ^{shift_q, par_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    assign data_out    = data_q;
    assign parity_out  = parity_q;
    assign trig_out    = trig_q;
    assign frame_valid = fv_q;
    assign framing_err = ferr_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx (DATA_W=4, CLKS_PER_BIT=4); honours SERIAL_PARITY_RX_LOCAL_CHECK_EN.
// Frame pulses are scored by a monitor against expected-word and start-cycle queues.
module tb_serial_parity_rx;

    localparam int CPB = 4;
    localparam int LAT = 27;  // start-bit drive to stop-sample pulse: 1 + CPB/2 + 6*CPB

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       mode_in;
    logic [3:0] data_out;
    logic       parity_out;
    logic       trig_out;
    logic       frame_valid;
    logic       framing_err;
    logic       busy;
    logic       perr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fv_cnt  = 0;
    int ferr_cnt = 0;

    logic [6:0] exp_q[$];
    int         lat_q[$];
    logic [6:0] exp_word;

    serial_parity_rx #(
        .DATA_W      (4),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .mode_in    (mode_in),
        .data_out   (data_out),
        .parity_out (parity_out),
        .trig_out   (trig_out),
        .frame_valid(frame_valid),
        .framing_err(framing_err),
        .busy       (busy),
        .perr       (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_perr(input logic [3:0] d, input logic p, input logic m);
`ifdef SERIAL_PARITY_RX_LOCAL_CHECK_EN
        return m ? ~(^{d, p}) : ^{d, p};
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && (frame_valid || framing_err)) begin
            check("pulse_exclusive", 32'(frame_valid & framing_err), 0);
            if (lat_q.size() == 0) check("pulse_unexpected", 1, 0);
            else check("pulse_latency", cyc - lat_q.pop_front(), LAT);
            if (frame_valid) begin
                fv_cnt++;
                if (exp_q.size() == 0) begin
                    check("fv_unexpected", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("frame_word", 32'({perr, trig_out, parity_out, data_out}), 32'(exp_word));
                end
            end
            if (framing_err) ferr_cnt++;
        end
    end

    task automatic drive(input logic b, input int n);
        sin = b;
        repeat (n) @(negedge clk);
    endtask

    // Caller must be at a falling edge; the task also ends on one.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic m0, input logic m1,
                              input logic stop, input int stop_n, input bit abort);
        mode_in = m0;
        if (!abort) begin
            lat_q.push_back(cyc);
            if (stop) exp_q.push_back({exp_perr(d, p, m0), m0, p, d});
        end
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) mode_in = m1;
            sin = d[i];
            if (i == 0) check("busy_mid_frame", 32'(busy), 1);
            repeat (CPB) @(negedge clk);
        end
        if (abort) begin
            drive(p, 2);
            rst_n = 1'b0;
            #1;
            check("abort_word", 32'({perr, trig_out, parity_out, data_out}), 0);
            check("abort_pulses", 32'({frame_valid, framing_err, busy}), 0);
            @(negedge clk);
            rst_n = 1'b1;
            sin = 1'b1;
            return;
        end
        drive(p, CPB);
        drive(stop, stop_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        sin     = 1'b1;
        mode_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_word", 32'({perr, trig_out, parity_out, data_out}), 0);
        check("reset_flags", 32'({frame_valid, framing_err, busy}), 0);
        rst_n = 1'b1;
        drive(1'b1, 3);
        check("idle_after_reset", 32'({busy, data_out}), 0);

        // Good frame 4'hB, parity 1, odd mode
        send_frame(4'hB, 1'b1, 1'b0, 1'b0, 1'b1, CPB, 0);
        drive(1'b1, 4);
        check("good_b_data", 32'(data_out), 32'h0B);
        check("good_b_par_trig", 32'({parity_out, trig_out}), 32'b10);
        check("good_b_count", fv_cnt, 1);
        check("good_b_idle", 32'({busy, frame_valid}), 0);

        // False start: one low cycle
        drive(1'b0, 1);
        check("false_start_busy", 32'(busy), 1);
        drive(1'b1, 6);
        check("false_start_idle", 32'(busy), 0);
        check("false_start_pulses", fv_cnt * 10 + ferr_cnt, 10);
        check("false_start_hold", 32'(data_out), 32'h0B);

        // Framing error: stop held low, then good 4'h3
        send_frame(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0);
        check("ferr_wait_busy", 32'(busy), 1);
        drive(1'b1, 4);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_fv", fv_cnt, 1);
        check("ferr_hold_data", 32'({parity_out, data_out}), 32'h1B);
        check("ferr_idle", 32'(busy), 0);
        send_frame(4'h3, 1'b1, 1'b0, 1'b0, 1'b1, CPB, 0);
        drive(1'b1, 4);
        check("after_ferr_data", 32'(data_out), 32'h03);
        check("after_ferr_count", fv_cnt, 2);

        // Mode captured at start, toggled mid-data
        send_frame(4'h9, 1'b0, 1'b1, 1'b0, 1'b1, CPB, 0);
        drive(1'b1, 4);
        check("mode_trig", 32'(trig_out), 1);
        check("mode_data", 32'(data_out), 32'h09);

        // Reset during parity
        send_frame(4'hC, 1'b1, 1'b0, 1'b0, 1'b1, CPB, 1);
        drive(1'b1, 40);
        check("abort_no_pulse", fv_cnt * 10 + ferr_cnt, 31);
        check("abort_data_zero", 32'(data_out), 0);

        // Back-to-back: second start lands in the frame_valid cycle
        send_frame(4'hA, 1'b0, 1'b0, 1'b0, 1'b1, CPB - 1, 0);
        check("b2b_first_data", 32'(data_out), 32'h0A);
        send_frame(4'h6, 1'b0, 1'b0, 1'b0, 1'b1, CPB, 0);
        drive(1'b1, 4);
        check("b2b_second_data", 32'(data_out), 32'h06);
        check("b2b_count", fv_cnt, 5);

        // Local parity check
        send_frame(4'hB, 1'b0, 1'b0, 1'b0, 1'b1, CPB, 0);
        drive(1'b1, 4);
`ifdef SERIAL_PARITY_RX_LOCAL_CHECK_EN
        check("perr_b_p0", 32'(perr), 1);
`else
        check("perr_b_p0", 32'(perr), 0);
`endif
        send_frame(4'hB, 1'b1, 1'b0, 1'b0, 1'b1, CPB, 0);
        drive(1'b1, 4);
        check("perr_b_p1", 32'(perr), 0);
        check("final_count", fv_cnt * 10 + ferr_cnt, 71);

        check("exp_q_drained", exp_q.size(), 0);
        check("lat_q_drained", lat_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
